fifo_wr_arb_ctrl: RTL

Write-side controller for the asynchronous FIFO, running entirely in the write clock domain. It arbitrates between two producers with round-robin fairness and drives the dual-port RAM write port. It maintains the binary and Gray write pointers and computes full, almost-full and free-slot count against the read pointer after the two-flop read-to-write synchronizer. It sits between the producers and the FIFO memory, and its Gray pointer feeds the write-to-read synchronizer.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/gray2bin.sv | 16 +
 rtl/fifo_wr_arb_ctrl.sv | 95 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared asynchronous-FIFO definitions: default geometry, grant encoding and
// binary-to-Gray conversion used by both pointer domains.
package fifo_pkg;

  localparam int unsigned FIFO_ADDRSIZE = 6;
  localparam int unsigned FIFO_DEPTH    = 1 << FIFO_ADDRSIZE;

  localparam logic GNT0 = 1'b0;
  localparam logic GNT1 = 1'b1;

  // Callers cast the result back to their pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter; bit i is the XOR of Gray bits i and above.
module gray2bin #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < W; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/fifo_wr_arb_ctrl.sv
// Write-side controller of the async FIFO: round-robin arbitration of two
// producers, RAM write port, write pointers and full/almost-full/free tracking.
module fifo_wr_arb_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE     = 6,
  parameter int unsigned DATASIZE     = 8,
  parameter int unsigned AFULL_THRESH = 4
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic                req0_valid,
  input  logic [DATASIZE-1:0] req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [DATASIZE-1:0] req1_data,
  output logic                req1_ready,
  output logic                wclken,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [DATASIZE-1:0] wdata,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wfree
);

  localparam int unsigned PW    = ADDRSIZE + 1;
  localparam int unsigned DEPTH = 1 << ADDRSIZE;

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] wfree_next;
  logic          wfull_next;
  logic          walmost_full_next;
  logic          last_gnt;
  logic          winner;
  logic          winner_valid;
  logic          accept;

  gray2bin #(.W(PW)) u_rptr_g2b (
    .gray (wq2_rptr),
    .bin  (rbin)
  );

  // Round-robin: on contention the producer that did not win last time goes.
  always_comb begin
    winner = GNT0;
    if (req0_valid && req1_valid) begin
      winner = ~last_gnt;
    end else if (req1_valid) begin
      winner = GNT1;
    end
    winner_valid = req0_valid | req1_valid;
    accept       = winner_valid && !wfull && wrst_n;
    req0_ready   = accept && (winner == GNT0);
    req1_ready   = accept && (winner == GNT1);
    wclken       = accept;
    waddr        = wbin[ADDRSIZE-1:0];
    wdata        = (winner == GNT1) ? req1_data : req0_data;
  end

  // Full when the next write pointer laps the synchronized read pointer.
  always_comb begin
    wbin_next         = wbin + PW'(accept);
    wgray_next        = PW'(bin2gray(32'(wbin_next)));
    wfull_next        = (wgray_next == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                                         wq2_rptr[ADDRSIZE-2:0]});
    wfree_next        = PW'(DEPTH) - (wbin_next - rbin);
    walmost_full_next = (wfree_next <= PW'(AFULL_THRESH));
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      last_gnt     <= GNT1;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wfree        <= PW'(DEPTH);
    end else begin
      wbin         <= wbin_next;
      wptr         <= wgray_next;
      wfull        <= wfull_next;
      walmost_full <= walmost_full_next;
      wfree        <= wfree_next;
      if (accept) begin
        last_gnt <= winner;
      end
    end
  end

endmodule
